// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared definitions for the RV32I control path.
// Holds the multi-cycle FSM state enum, the opcodes the control unit
// understands, and the mux/ALU encodings that the datapath and the
// pipelined core agree on.
package core_ctrl_pkg;

    // Encoding is visible on state_o, so keep it stable.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_FAULT    = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUControl encoding; ADD is zero so idle states read as ADD.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // States that own the shared memory port.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational ALU operation decode, shared with the
// pipelined core.
//   alu_op      in  2  00 = add, 01 = sub, 10 = decode from funct fields
//   funct3      in  3  instruction funct3
//   funct7b5    in  1  instruction bit 30
//   op5         in  1  opcode bit 5 (1 = register-register form)
//   alu_control out 4  ALU operation
module alu_decoder
    import core_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // addi has no subtract form, so bit 30 only counts for R-type.
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RV32I control unit.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared memory and
// drives the multi-cycle datapath muxes and register enables.
//   clk, reset (async, active-low)
//   op, funct3, funct7b5, Zero, mem_ready     inputs from IR / ALU / memory
//   mem_req, MemWrite, MemRead, AdrSrc        memory port control
//   IRWrite, PCWrite, RegWrite                register enables
//   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
//   ALUControl                                datapath selects
//   fault                                     sticky error flag
//   state_o                                   current state (debug)
//
// Memory handshake: mem_req is high for the whole of a memory state. With
// MEM_HANDSHAKE=1 an access completes in the cycle where mem_req and
// mem_ready are both high; mem_ready at any other time is ignored. With
// MEM_HANDSHAKE=0 it completes after exactly MEM_LATENCY cycles. Either way
// an access stalled for TIMEOUT cycles forces FAULT (TIMEOUT must be
// greater than MEM_LATENCY and at most 64).
module multicycle_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int MEM_LATENCY   = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       fault,
    output logic [3:0] state_o
);

    localparam logic [5:0] LAT_LAST = 6'(MEM_LATENCY - 1);
    localparam logic [5:0] TO_LAST  = 6'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [5:0] wait_cnt_q, wait_cnt_d;
    logic       fault_q, fault_d;
    logic       in_mem, mem_done, timed_out;
    logic [1:0] alu_op;
    logic [3:0] alu_ctrl;

    always_comb begin
        in_mem = is_mem_state(state_q);
        if (MEM_HANDSHAKE) mem_done = in_mem && mem_ready;
        else               mem_done = in_mem && (wait_cnt_q == LAT_LAST);
        // Counting the current stalled cycle, TIMEOUT waits would be reached.
        timed_out = in_mem && !mem_done && (wait_cnt_q >= TO_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FAULT;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_done) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_done) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FAULT;
        endcase
        if (timed_out) state_d = S_FAULT;

        // Any state change clears the counter, so it is zero on entry to
        // every memory state; it only advances while a memory state stalls.
        if (in_mem && (state_d == state_q))
            wait_cnt_d = (wait_cnt_q >= TO_LAST) ? wait_cnt_q : wait_cnt_q + 6'd1;
        else
            wait_cnt_d = '0;

        fault_d = fault_q || (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        case (state_q)
            S_EXECR, S_EXECI: alu_op = ALUOP_FUNCT;
            S_BRANCH:         alu_op = ALUOP_SUB;
            default:          alu_op = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_ctrl)
    );

    // Moore decode of state_q; every strobe is also gated by reset so an
    // asserted reset drops them immediately, even mid-access.
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_B;
        ResultSrc = RES_ALUOUT;
        ImmSrc    = IMM_I;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_done;
                PCWrite   = mem_done;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_EXECR: ALUSrcA = SRCA_A;
            S_EXECI: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_A;
                if (funct3 == 3'b000)      PCWrite = Zero;
                else if (funct3 == 3'b001) PCWrite = !Zero;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            mem_req   = 1'b0;
            MemWrite  = 1'b0;
            MemRead   = 1'b0;
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_B;
            ResultSrc = RES_ALUOUT;
            ImmSrc    = IMM_I;
        end
    end

    assign ALUControl = reset ? alu_ctrl : ALU_ADD;
    assign fault      = fault_q;
    assign state_o    = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Parametrised multi-cycle control unit for the RV32I core, the successor to the single-cycle control path. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states over a shared instruction/data memory and stalls on a memory handshake. Two memory modes are supported: ready-driven or fixed-latency. A watchdog raises a sticky fault on a hung memory access or an unsupported opcode. It drives the multi-cycle datapath (IR, PC, A/B, ALUOut and Data registers) in place of the combinational control unit.

## Interface
- MEM_HANDSHAKE, 1: 1 = wait for mem_ready; 0 = fixed latency of MEM_LATENCY cycles.
- MEM_LATENCY, 2: cycles per memory access when MEM_HANDSHAKE=0; legal range 1..15.
- TIMEOUT, 64: maximum wait cycles per access before FAULT; must be > MEM_LATENCY.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- op  in  7  opcode from IR (Instr[6:0]); stable from DECODE onward.
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- Zero  in  1  ALU zero flag from the datapath.
- mem_ready  in  1  memory completion strobe; ignored when MEM_HANDSHAKE=0.
- mem_req  out  1  memory access in progress.
- MemWrite  out  1  store strobe, high throughout MEMWRITE.
- MemRead  out  1  load/fetch read, high throughout FETCH and MEMREAD.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- IRWrite  out  1  capture instruction; one cycle, on fetch completion.
- PCWrite  out  1  PC update (fetch completion, JAL, or taken branch).
- RegWrite  out  1  register-file write.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A.
- ALUSrcB  out  2  00 = B, 01 = Imm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  4  ALU operation, using the existing core encoding.
- fault  out  1  sticky error flag.
- state_o  out  4  current state, for debug and the bench.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, FAULT.
- FETCH: mem_req=1, MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - On completion: IRWrite=1, PCWrite=1, go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10 (branch target precompute). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → FAULT
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc = S for stores, I for loads. Go to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, MemRead=1, AdrSrc=1. On completion go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. On completion go to FETCH.
- EXECR/EXECI: ALUSrcA=10, ALUSrcB=00/01, ALUControl decoded from funct3/funct7b5, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=SUB.
  - PCWrite = Zero for funct3=000 (beq), !Zero for funct3=001 (bne).
  - Other funct3 values: no PCWrite. Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, then ALUWB.
- Access completion:
  - MEM_HANDSHAKE=1: the cycle in which mem_ready=1 while mem_req=1.
  - MEM_HANDSHAKE=0: the cycle in which the wait counter equals MEM_LATENCY-1.
- Wait counter (6-bit saturating at TIMEOUT):
  - Clears on entry to every memory state; increments each stalled cycle.
  - Reaching TIMEOUT without completion → FAULT.
- FAULT: all strobes 0, fault=1. Stays in FAULT until reset.
- All outputs not listed for a state are 0.

## Timing
- Reset (async assert, sync-free release):
  - state=FETCH, counter=0, fault=0.
  - All strobes 0 except the combinational FETCH levels (mem_req=1, MemRead=1) once reset=1.
- Outputs are Moore decodes of state, plus combinational funct/Zero terms in EXECR/EXECI/BRANCH.
- Latency with a zero-wait memory (handshake, mem_ready held high):
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL: 4 cycles
- Each memory wait cycle adds 1.
- mem_ready arriving outside a memory state is ignored.
- Reset asserted mid-access aborts immediately; no partial strobe is left asserted.

## Structure
- Shared package core_ctrl_pkg holds:
  - the state enum
  - opcode constants
  - ALUControl, ImmSrc, ALUSrcA/B and ResultSrc encodings
- Sub-module alu_decoder (combinational; ALUOp, funct3, funct7b5, op[5] → ALUControl), shared with the pipelined core.

## Test plan
- Reset, then mem_ready=1 with op=0110011, funct3=000, funct7b5=1 → states FETCH,DECODE,EXECR,ALUWB,FETCH; ALUControl=SUB in EXECR; RegWrite=1 only in ALUWB.
- Load, op=0000011, handshake mode, mem_ready low 3 cycles in MEMREAD → MEMREAD lasts 4 cycles; MemWB RegWrite with ResultSrc=01; total 8 cycles.
- MEM_HANDSHAKE=0, MEM_LATENCY=3, store → FETCH 3 cycles and MEMWRITE 3 cycles; MemWrite high for exactly 3 cycles.
- op=1100011: funct3=000, Zero=1 → PCWrite in BRANCH; funct3=001, Zero=1 → no PCWrite.
- mem_ready held 0 in FETCH, TIMEOUT=64 → FAULT after 64 cycles; fault stays 1 until reset=0, then returns to FETCH.
- op=1110011 (unsupported) → FAULT from DECODE; reset asserted mid-MEMREAD → state=FETCH and MemRead drops asynchronously.
